// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, ALU select encodings,
// instruction field offsets and a select-line decoder.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_INV   = 4'd2;
    localparam logic [3:0] OP_SHL   = 4'd3;
    localparam logic [3:0] OP_SHR   = 4'd4;
    localparam logic [3:0] OP_CMPEQ = 4'd5;
    localparam logic [3:0] OP_CMPLT = 4'd6;
    localparam logic [3:0] OP_LDI   = 4'd7;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 10;
    localparam int RA_LSB = 8;
    localparam int RB_LSB = 6;

    localparam logic [1:0] SEL0_AND = 2'd0;
    localparam logic [1:0] SEL0_ADD = 2'd1;
    localparam logic [1:0] SEL0_INV = 2'd2;
    localparam logic [1:0] SEL0_SHL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic       cf_sel;
        logic [1:0] alu_sel_0;
        logic       alu_sel_1;
        logic       inv_sel;
        logic       shftr_sel;
        logic       shftl_sel;
    } alu_sel_t;

    function automatic logic op_legal(input logic [3:0] op);
        return !op[3];
    endfunction

    function automatic logic op_is_cmp(input logic [3:0] op);
        return (op == OP_CMPEQ) || (op == OP_CMPLT);
    endfunction

    // Direction selects (inv/shftl/shftr) stay 0 for every supported op.
    function automatic alu_sel_t decode_sel(input logic [3:0] op);
        alu_sel_t s;
        s = '0;
        case (op)
            OP_ADD:   s.alu_sel_0 = SEL0_ADD;
            OP_INV:   s.alu_sel_0 = SEL0_INV;
            OP_SHL:   s.alu_sel_0 = SEL0_SHL;
            OP_SHR:   s.alu_sel_1 = 1'b1;
            OP_CMPEQ: s.cf_sel    = 1'b1;
            default:  s.alu_sel_0 = SEL0_AND;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Instruction and result handshake bundle between the sequencer and its neighbours.
interface alu_seq_if;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [15:0] instr_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [7:0]  res_data_o;
    logic        res_cf_o;
    logic        err_o;

    modport slave (
        input  instr_valid_i, instr_i, res_ready_i,
        output instr_ready_o, res_valid_o, res_data_o, res_cf_o, err_o
    );

    modport master (
        output instr_valid_i, instr_i, res_ready_i,
        input  instr_ready_o, res_valid_o, res_data_o, res_cf_o, err_o
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// synchronous reset of every entry to RST_VAL.
module alu_seq_regfile #(
    parameter int         AW      = 2,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [7:0]    ra_data,
    output logic [7:0]    rb_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd
);
    localparam int N = 1 << AW;

    logic [7:0] mem [N];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) mem[i] <= RST_VAL;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle sequencer feeding an external ALU; owns the register file and writes back.
// Define ALU_SEQ_FAST_EN to drop the READ state (operands latched on the accept edge).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int         REG_AW  = 2,
    parameter logic [7:0] REG_RST = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    alu_seq_if.slave    bus,
    output logic        cf_sel_o,
    output logic [1:0]  alu_sel_0_o,
    output logic        alu_sel_1_o,
    output logic        inv_sel_o,
    output logic        shftr_sel_o,
    output logic        shftl_sel_o,
    output logic [7:0]  oprnd_0_o,
    output logic [7:0]  oprnd_1_o,
    input  logic [7:0]  alu_result_i,
    input  logic        cf_i
);
    state_t            state;
    alu_sel_t          sel_q;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q, ra_q, rb_q;
    logic [7:0]        imm_q;
    logic [REG_AW-1:0] ra_addr, rb_addr;
    logic [7:0]        ra_data, rb_data;
    logic [3:0]        op_in;
    logic              we;

    assign op_in = bus.instr_i[OP_LSB +: 4];

    // In IDLE the read ports look straight at the incoming instruction (fast accept path).
    assign ra_addr = (state == ST_IDLE) ? bus.instr_i[RA_LSB +: REG_AW] : ra_q;
    assign rb_addr = (state == ST_IDLE) ? bus.instr_i[RB_LSB +: REG_AW] : rb_q;

    assign we = (state == ST_WB) && bus.res_ready_i && !op_is_cmp(op_q);

    alu_seq_regfile #(.AW(REG_AW), .RST_VAL(REG_RST)) u_rf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ra_addr (ra_addr),
        .rb_addr (rb_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (we),
        .wa      (rd_q),
        .wd      (bus.res_data_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            bus.instr_ready_o <= 1'b1;
            bus.res_valid_o   <= 1'b0;
            bus.res_data_o    <= '0;
            bus.res_cf_o      <= 1'b0;
            bus.err_o         <= 1'b0;
            sel_q             <= '0;
            oprnd_0_o         <= '0;
            oprnd_1_o         <= '0;
            op_q              <= '0;
            rd_q              <= '0;
            ra_q              <= '0;
            rb_q              <= '0;
            imm_q             <= '0;
        end else begin
            bus.err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid_i) begin
                        if (op_legal(op_in)) begin
                            op_q              <= op_in;
                            rd_q              <= bus.instr_i[RD_LSB +: REG_AW];
                            ra_q              <= bus.instr_i[RA_LSB +: REG_AW];
                            rb_q              <= bus.instr_i[RB_LSB +: REG_AW];
                            imm_q             <= bus.instr_i[7:0];
                            sel_q             <= decode_sel(op_in);
                            bus.instr_ready_o <= 1'b0;
`ifdef ALU_SEQ_FAST_EN
                            oprnd_0_o         <= ra_data;
                            oprnd_1_o         <= rb_data;
                            state             <= ST_EXEC;
`else
                            state             <= ST_READ;
`endif
                        end else begin
                            bus.err_o <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    oprnd_0_o <= ra_data;
                    oprnd_1_o <= rb_data;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_q == OP_LDI)     bus.res_data_o <= imm_q;
                    else if (op_is_cmp(op_q)) bus.res_data_o <= '0;
                    else                    bus.res_data_o <= alu_result_i;
                    bus.res_cf_o    <= (op_q == OP_LDI) ? 1'b0 : cf_i;
                    bus.res_valid_o <= 1'b1;
                    state           <= ST_WB;
                end
                ST_WB: begin
                    if (bus.res_ready_i) begin
                        bus.res_valid_o   <= 1'b0;
                        bus.instr_ready_o <= 1'b1;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cf_sel_o    = sel_q.cf_sel;
    assign alu_sel_0_o = sel_q.alu_sel_0;
    assign alu_sel_1_o = sel_q.alu_sel_1;
    assign inv_sel_o   = sel_q.inv_sel;
    assign shftr_sel_o = sel_q.shftr_sel;
    assign shftl_sel_o = sel_q.shftl_sel;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU stand-in, register-file reference model,
// directed scenarios followed by randomized instruction streams.
module tb_alu_seq;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cf_sel, alu_sel_1, inv_sel, shftr_sel, shftl_sel;
    logic [1:0] alu_sel_0;
    logic [7:0] oprnd_0, oprnd_1, alu_result;
    logic       cf;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] R [4];

`ifdef ALU_SEQ_FAST_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 3;
`endif

    always #5 clk_i = ~clk_i;

    alu_seq_if bus();

    alu_seq #(.REG_AW(2), .REG_RST(8'h00)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .cf_sel_o     (cf_sel),
        .alu_sel_0_o  (alu_sel_0),
        .alu_sel_1_o  (alu_sel_1),
        .inv_sel_o    (inv_sel),
        .shftr_sel_o  (shftr_sel),
        .shftl_sel_o  (shftl_sel),
        .oprnd_0_o    (oprnd_0),
        .oprnd_1_o    (oprnd_1),
        .alu_result_i (alu_result),
        .cf_i         (cf)
    );

    // Stand-in for the downstream ALU the parent would instantiate.
    always_comb begin
        alu_result = 8'h00;
        if (alu_sel_1) alu_result = oprnd_0 >> 1;
        else case (alu_sel_0)
            2'd0: alu_result = oprnd_0 & oprnd_1;
            2'd1: alu_result = oprnd_0 + oprnd_1;
            2'd2: alu_result = ~oprnd_0;
            default: alu_result = oprnd_0 << 1;
        endcase
        cf = cf_sel ? (oprnd_0 == oprnd_1) : (oprnd_0 < oprnd_1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] imm, input int hold);
        logic [15:0] ins;
        logic [7:0]  a, b, exp_d;
        logic        exp_cf;
        logic [6:0]  exp_sel, s_sel;
        logic [7:0]  s_op0, s_op1;
        int          lat;

        if (op == 4'd7) ins = {op, rd, ra, imm};
        else            ins = {op, rd, ra, rb, 6'd0};
        a = R[ins[9:8]];
        b = R[ins[7:6]];

        case (op)
            4'd0: exp_d = a & b;
            4'd1: exp_d = a + b;
            4'd2: exp_d = ~a;
            4'd3: exp_d = {a[6:0], 1'b0};
            4'd4: exp_d = {1'b0, a[7:1]};
            4'd7: exp_d = imm;
            default: exp_d = 8'h00;
        endcase
        case (op)
            4'd5: exp_cf = (a == b);
            4'd7: exp_cf = 1'b0;
            default: exp_cf = (a < b);
        endcase
        // {cf_sel, alu_sel_0, alu_sel_1, inv_sel, shftr_sel, shftl_sel}
        case (op)
            4'd1: exp_sel = 7'b0_01_0000;
            4'd2: exp_sel = 7'b0_10_0000;
            4'd3: exp_sel = 7'b0_11_0000;
            4'd4: exp_sel = 7'b0_00_1000;
            4'd5: exp_sel = 7'b1_00_0000;
            default: exp_sel = 7'b0_00_0000;
        endcase

        bus.res_ready_i   = (hold == 0);
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = ins;
        chk("instr_ready_idle", 32'(bus.instr_ready_o), 32'd1);
        step();
        bus.instr_valid_i = 1'b0;
        lat   = 1;
        s_sel = '0;
        s_op0 = '0;
        s_op1 = '0;
        while (!bus.res_valid_o && lat < 10) begin
            s_sel = {cf_sel, alu_sel_0, alu_sel_1, inv_sel, shftr_sel, shftl_sel};
            s_op0 = oprnd_0;
            s_op1 = oprnd_1;
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(EXP_LAT));
        chk("res_data", 32'(bus.res_data_o), 32'(exp_d));
        chk("res_cf", 32'(bus.res_cf_o), 32'(exp_cf));
        if (op != 4'd7) begin
            chk("selects", 32'(s_sel), 32'(exp_sel));
            chk("oprnd_0", 32'(s_op0), 32'(a));
            chk("oprnd_1", 32'(s_op1), 32'(b));
        end
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(bus.res_valid_o), 32'd1);
            chk("hold_data", 32'(bus.res_data_o), 32'(exp_d));
            chk("hold_instr_ready", 32'(bus.instr_ready_o), 32'd0);
            step();
        end
        bus.res_ready_i = 1'b1;
        step();
        chk("post_wb_valid", 32'(bus.res_valid_o), 32'd0);
        chk("post_wb_ready", 32'(bus.instr_ready_o), 32'd1);
        if (op != 4'd5 && op != 4'd6) R[rd] = exp_d;
    endtask

    // AND r,r,r rewrites the same value, so it reads a register back without disturbing it.
    task automatic peek(input logic [1:0] r);
        issue(4'd0, r, r, r, 8'h00, 0);
    endtask

    task automatic illegal(input logic [3:0] op);
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = {op, 12'($urandom)};
        step();
        bus.instr_valid_i = 1'b0;
        chk("err_pulse", 32'(bus.err_o), 32'd1);
        chk("err_ready", 32'(bus.instr_ready_o), 32'd1);
        step();
        chk("err_clear", 32'(bus.err_o), 32'd0);
    endtask

    initial begin
        rst_i             = 1'b1;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        bus.res_ready_i   = 1'b1;
        for (int i = 0; i < 4; i++) R[i] = 8'h00;
        step();
        step();
        chk("rst_instr_ready", 32'(bus.instr_ready_o), 32'd1);
        chk("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_res_data", 32'(bus.res_data_o), 32'd0);
        chk("rst_outs", 32'({bus.res_cf_o, cf_sel, alu_sel_0, alu_sel_1, inv_sel,
                             shftr_sel, shftl_sel, oprnd_0, oprnd_1}), 32'd0);
        rst_i = 1'b0;

        // basic add chain
        issue(4'd7, 2'd1, 2'd0, 2'd0, 8'h05, 0);
        issue(4'd7, 2'd2, 2'd0, 2'd0, 8'h03, 0);
        issue(4'd1, 2'd3, 2'd1, 2'd2, 8'h00, 0);
        peek(2'd3);

        // wrap and shifts
        issue(4'd7, 2'd0, 2'd0, 2'd0, 8'hF0, 0);
        issue(4'd7, 2'd1, 2'd0, 2'd0, 8'h20, 0);
        issue(4'd1, 2'd2, 2'd0, 2'd1, 8'h00, 0);
        issue(4'd4, 2'd3, 2'd0, 2'd0, 8'h00, 0);
        issue(4'd3, 2'd3, 2'd0, 2'd0, 8'h00, 0);

        // compares leave rd alone
        issue(4'd7, 2'd1, 2'd0, 2'd0, 8'h05, 0);
        issue(4'd7, 2'd2, 2'd0, 2'd0, 8'h05, 0);
        issue(4'd5, 2'd0, 2'd1, 2'd2, 8'h00, 0);
        issue(4'd7, 2'd2, 2'd0, 2'd0, 8'h06, 0);
        issue(4'd6, 2'd3, 2'd1, 2'd2, 8'h00, 0);
        peek(2'd0);
        peek(2'd3);

        // backpressure in WB
        issue(4'd1, 2'd0, 2'd1, 2'd2, 8'h00, 5);
        peek(2'd0);

        // illegal opcode
        illegal(4'hC);
        peek(2'd1);

        // reset during EXEC of an ADD
        issue(4'd7, 2'd3, 2'd0, 2'd0, 8'h5A, 0);
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = {4'd1, 2'd3, 2'd1, 2'd2, 6'd0};
        step();
        bus.instr_valid_i = 1'b0;
        repeat (EXP_LAT - 2) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midrst_valid", 32'(bus.res_valid_o), 32'd0);
        chk("midrst_ready", 32'(bus.instr_ready_o), 32'd1);
        chk("midrst_data", 32'(bus.res_data_o), 32'd0);
        for (int i = 0; i < 4; i++) R[i] = 8'h00;
        peek(2'd3);

        // randomized stream
        for (int n = 0; n < 60; n++) begin
            int op;
            op = int'($urandom_range(0, 8));
            if (op == 8) illegal(4'(8 + $urandom_range(0, 7)));
            else issue(4'(op), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                       int'($urandom_range(0, 2)));
        end
        for (int r = 0; r < 4; r++) peek(2'(r));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
